// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the two-digit seven-segment scan driver.
package seven_seg_pkg;

  localparam int unsigned CNT_W = 20;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    GAP_ONES,
    SHOW_ONES,
    GAP_TENS,
    SHOW_TENS
  } state_t;

  localparam logic [6:0] SEG_ZERO = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  localparam int TENS_MSB = 13;
  localparam int TENS_LSB = 7;
  localparam int ONES_MSB = 6;
  localparam int ONES_LSB = 0;

  function automatic state_t next_phase(state_t s);
    case (s)
      GAP_ONES:  return SHOW_ONES;
      SHOW_ONES: return GAP_TENS;
      GAP_TENS:  return SHOW_TENS;
      default:   return GAP_ONES;
    endcase
  endfunction

  function automatic logic is_gap(state_t s);
    return (s == GAP_ONES) || (s == GAP_TENS);
  endfunction

endpackage

// File: rtl/seven_segment_scan_driver_if.sv
// Encoder-side word input and display-side scan outputs of the scan driver.
interface seven_segment_scan_driver_if;
  logic [13:0] Seg_In;
  logic        Seg_Valid;
  logic        Blank_Lz;
  logic [6:0]  Seg_Out;
  logic [1:0]  Digit_En;
  logic        Frame_Done;

  modport master (
    output Seg_In, Seg_Valid, Blank_Lz,
    input  Seg_Out, Digit_En, Frame_Done
  );

  modport slave (
    input  Seg_In, Seg_Valid, Blank_Lz,
    output Seg_Out, Digit_En, Frame_Done
  );
endinterface

// File: rtl/scan_phase_timer.sv
// Phase counter that restarts itself on its own terminal count; also reports whether the
// following cycle will be the last one of its phase so callers can register that flag.
module scan_phase_timer
  import seven_seg_pkg::*;
(
  input  logic Clk,
  input  logic Rst_n,
  input  cnt_t len,       // length of the phase in progress
  input  cnt_t len_next,  // length of the phase the next cycle belongs to
  output logic last,
  output logic last_next
);

  cnt_t count_q, count_d;

  always_comb begin
    last      = (count_q == len - cnt_t'(1));
    count_d   = last ? '0 : count_q + cnt_t'(1);
    last_next = (count_d == len_next - cnt_t'(1));
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/seven_segment_scan_driver.sv
// Two-digit multiplexed seven-segment driver with dead time and frame-aligned word updates.
module seven_segment_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV      = 50000,
  parameter int unsigned DEAD_CYCLES      = 2,
  parameter bit          SEG_ACTIVE_LOW   = 1'b1,
  parameter bit          DIGIT_ACTIVE_LOW = 1'b1
) (
  input logic                        Clk,
  input logic                        Rst_n,
  seven_segment_scan_driver_if.slave bus
);

  // Output registers hold the idle pattern XOR'ed with active-high data.
  localparam logic [6:0] SEG_IDLE = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic [1:0] DIG_IDLE = DIGIT_ACTIVE_LOW ? 2'b11 : 2'b00;

  state_t      state_q, state_d;
  logic [13:0] shadow_q, shadow_d;
  logic [13:0] display_q, display_d;
  logic        pending_q, pending_d;
  logic        last, last_next, boundary;
  cnt_t        len_cur, len_nxt;

  logic [6:0]  seg_nxt, seg_q;
  logic [1:0]  en_nxt, en_q;
  logic        fd_nxt, fd_q;
  logic [6:0]  tens_pat;

  function automatic cnt_t phase_len(state_t s);
    return is_gap(s) ? cnt_t'(DEAD_CYCLES) : cnt_t'(REFRESH_DIV);
  endfunction

  scan_phase_timer u_timer (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .len       (len_cur),
    .len_next  (len_nxt),
    .last      (last),
    .last_next (last_next)
  );

  always_comb begin
    len_cur  = phase_len(state_q);
    state_d  = last ? next_phase(state_q) : state_q;
    len_nxt  = phase_len(state_d);
    boundary = (state_q == SHOW_TENS) && last;
  end

  always_comb begin
    shadow_d  = shadow_q;
    pending_d = pending_q;
    display_d = display_q;
    if (bus.Seg_Valid) begin
      shadow_d  = bus.Seg_In;
      pending_d = 1'b1;
    end
    // A strobe on the boundary cycle bypasses the shadow and lands in the next frame.
    if (boundary) begin
      if (bus.Seg_Valid) begin
        display_d = bus.Seg_In;
      end else if (pending_q) begin
        display_d = shadow_q;
      end
      pending_d = 1'b0;
    end
  end

  always_comb begin
    seg_nxt  = SEG_OFF;
    en_nxt   = 2'b00;
    tens_pat = display_q[TENS_MSB:TENS_LSB];
    case (state_d)
      SHOW_ONES: begin
        en_nxt  = 2'b01;
        seg_nxt = display_q[ONES_MSB:ONES_LSB];
      end
      SHOW_TENS: begin
        en_nxt  = 2'b10;
        seg_nxt = (bus.Blank_Lz && (tens_pat == SEG_ZERO)) ? SEG_OFF : tens_pat;
      end
      default: ;
    endcase
    fd_nxt = (state_d == SHOW_TENS) && last_next;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q   <= GAP_ONES;
      shadow_q  <= '0;
      display_q <= '0;
      pending_q <= 1'b0;
      seg_q     <= SEG_IDLE;
      en_q      <= DIG_IDLE;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      display_q <= display_d;
      pending_q <= pending_d;
      seg_q     <= seg_nxt ^ SEG_IDLE;
      en_q      <= en_nxt ^ DIG_IDLE;
      fd_q      <= fd_nxt;
    end
  end

  assign bus.Seg_Out    = seg_q;
  assign bus.Digit_En   = en_q;
  assign bus.Frame_Done = fd_q;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Scoreboard bench: expected lit/blank runs per frame are queued, a monitor checks each run.
module tb_seven_segment_scan_driver;

  localparam int R     = 4;
  localparam int D     = 2;
  localparam int FRAME = 2 * (R + D);

  typedef struct packed {
    logic [1:0] en;
    logic [6:0] seg;
    logic [7:0] len;
    logic [3:0] fd_cnt;
    logic       fd_last;
  } run_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seven_segment_scan_driver_if bus ();

  seven_segment_scan_driver #(
    .REFRESH_DIV      (R),
    .DEAD_CYCLES      (D),
    .SEG_ACTIVE_LOW   (1'b1),
    .DIGIT_ACTIVE_LOW (1'b1)
  ) dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  run_t sb[$];

  // Reference state: word-level view of what each frame should show.
  logic [13:0] m_shadow, m_display;
  logic        m_pending;
  logic        blz_next;
  int          t;

  logic [6:0] digit_pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [13:0] word2(input int tens, input int ones);
    return {digit_pat[tens], digit_pat[ones]};
  endfunction

  task automatic push_frame(input logic blz);
    logic [6:0] tens, ones, tens_seg;
    tens = m_display[13:7];
    ones = m_display[6:0];
    tens_seg = (blz && tens == 7'h3F) ? 7'h7F : ~tens;
    sb.push_back('{2'b11, 7'h7F, 8'(D), 4'd0, 1'b0});
    sb.push_back('{2'b10, ~ones, 8'(R), 4'd0, 1'b0});
    sb.push_back('{2'b11, 7'h7F, 8'(D), 4'd0, 1'b0});
    sb.push_back('{2'b01, tens_seg, 8'(R), 4'd1, 1'b1});
  endtask

  // Drives inputs for the edge that ends cycle t, updates the model, advances one cycle.
  task automatic tick(input logic v, input logic [13:0] w);
    int p;
    p = t % FRAME;
    if (p == 1) begin
      bus.Blank_Lz = blz_next;
      push_frame(blz_next);
    end
    bus.Seg_Valid = v;
    bus.Seg_In    = w;
    if (p == FRAME - 1) begin
      if (v) m_display = w;
      else if (m_pending) m_display = m_shadow;
      m_pending = 1'b0;
      if (v) m_shadow = w;
    end else if (v) begin
      m_shadow  = w;
      m_pending = 1'b1;
    end
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    bus.Seg_Valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    m_shadow  = '0;
    m_display = '0;
    m_pending = 1'b0;
    t = 0;
  endtask

  // One frame with up to two strobes at phases pa/pb (-1 = none); Seg_In is noise elsewhere.
  task automatic run_frame(input int pa, input logic [13:0] wa,
                           input int pb, input logic [13:0] wb, input logic blz);
    blz_next = blz;
    for (int p = 0; p < FRAME; p++) begin
      if (p == pa) tick(1'b1, wa);
      else if (p == pb) tick(1'b1, wb);
      else tick(1'b0, 14'($urandom));
    end
  endtask

  // Monitor: splits the output stream into constant runs and checks each against the queue.
  initial begin
    run_t cur, exp;
    logic r;
    bit   run_valid;
    run_valid = 0;
    cur = '0;
    forever begin
      @(posedge clk);
      r = rst_n;
      @(negedge clk);
      if (!r) begin
        check("reset_outputs", {22'd0, bus.Seg_Out, bus.Digit_En, bus.Frame_Done},
              {22'd0, 7'h7F, 2'b11, 1'b0});
        sb.delete();
        cur = '{2'b11, 7'h7F, 8'd1, 4'd0, 1'b0};
        run_valid = 1;
      end else begin
        if (bus.Digit_En == 2'b00) check("both_digits_on", 32'(bus.Digit_En), 32'd1);
        if (run_valid && bus.Digit_En == cur.en && bus.Seg_Out == cur.seg) begin
          cur.len++;
          cur.fd_cnt  = cur.fd_cnt + 4'(bus.Frame_Done);
          cur.fd_last = bus.Frame_Done;
        end else begin
          if (run_valid) begin
            if (sb.size() == 0) begin
              check("unexpected_run", 32'(cur), 32'hFFFF_FFFF);
            end else begin
              exp = sb.pop_front();
              check("scan_run", 32'(cur), 32'(exp));
            end
          end
          cur = '{bus.Digit_En, bus.Seg_Out, 8'd1, 4'(bus.Frame_Done), bus.Frame_Done};
          run_valid = 1;
        end
      end
    end
  end

  initial begin
    logic [13:0] w;
    bus.Seg_In    = '0;
    bus.Seg_Valid = 1'b0;
    bus.Blank_Lz  = 1'b0;
    blz_next      = 1'b0;

    do_reset(3);
    // Blank first frame, "24" strobed during it, then shown.
    run_frame(3, word2(2, 4), -1, '0, 1'b0);
    run_frame(-1, '0, -1, '0, 1'b0);
    // Mid-frame "99" during SHOW_ONES waits for the boundary.
    run_frame(3, word2(9, 9), -1, '0, 1'b0);
    run_frame(-1, '0, -1, '0, 1'b0);
    // Boundary collision: "81" just before the boundary, "72" on it.
    run_frame(FRAME - 2, word2(8, 1), FRAME - 1, word2(7, 2), 1'b0);
    run_frame(-1, '0, -1, '0, 1'b0);
    run_frame(-1, '0, -1, '0, 1'b0);
    // Leading-zero "03": blanked, then unblanked.
    run_frame(5, word2(0, 3), -1, '0, 1'b0);
    run_frame(-1, '0, -1, '0, 1'b1);
    run_frame(-1, '0, -1, '0, 1'b0);

    // Randomized frames: sparse strobes of two-digit words (tens biased toward zero).
    for (int f = 0; f < 20; f++) begin
      blz_next = 1'($urandom_range(1));
      for (int p = 0; p < FRAME; p++) begin
        w = word2(($urandom_range(2) == 0) ? 0 : int'($urandom_range(9)),
                  int'($urandom_range(9)));
        if ($urandom_range(7) == 0) tick(1'b1, w);
        else tick(1'b0, 14'($urandom));
      end
    end

    // Reset during SHOW_TENS with "12" pending; display must stay blank afterwards.
    blz_next = 1'b0;
    for (int p = 0; p < 9; p++) begin
      if (p == 3) tick(1'b1, word2(1, 2));
      else tick(1'b0, 14'($urandom));
    end
    do_reset(2);
    run_frame(-1, '0, -1, '0, 1'b0);
    run_frame(7, word2(5, 6), -1, '0, 1'b1);
    run_frame(-1, '0, -1, '0, 1'b1);

    @(negedge clk);
    #1;
    check("queue_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
